async_queue_source: RTL and testbench



---
 rtl/async_queue_pkg.sv | 26 ++
 rtl/async_queue_source_if.sv | 58 +++++
 rtl/async_reset_sync_shift_reg.sv | 31 +++
 rtl/async_queue_source.sv | 103 ++++++++++
 tb/tb_async_queue_source.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/async_queue_pkg.sv
// ----------------------------------------------------------------------------
// async_queue_pkg
// Helpers shared by both ends of the clock-domain-crossing queue
// (async_queue_source today, async_queue_sink later).
//   idx_bits(depth)  : width of a ring index with one wrap bit, $clog2(depth)+1
//   full_mask(depth) : Gray pattern that separates a full ring from an empty
//                      one (top two index bits set, depth | depth/2)
//   gray(bin)        : binary to reflected Gray code
// ----------------------------------------------------------------------------
package async_queue_pkg;

    function automatic int idx_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // In Gray code, "write is exactly DEPTH ahead of read" flips the top two
    // bits and leaves the rest equal.
    function automatic int full_mask(input int depth);
        return depth | (depth / 2);
    endfunction

    function automatic logic [31:0] gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/async_queue_source_if.sv
// ----------------------------------------------------------------------------
// async_queue_source_if
// Producer stream plus the crossing bus of the async queue source end.
//   io_enq_valid / io_enq_ready / io_enq_bits : producer valid/ready stream
//   io_async_mem   : ring contents, entry i at [i*WIDTH +: WIDTH]
//   io_async_widx  : Gray write index (from a flop, to the consumer domain)
//   io_async_ridx  : Gray read index (from the consumer domain, asynchronous)
// With ASYNC_QUEUE_SOURCE_VALID_EN defined:
//   io_async_source_valid : liveness level of this end
//   io_async_sink_valid   : liveness level of the consumer end (asynchronous)
// Modports: master = queue source block, slave = producer/consumer side.
// ----------------------------------------------------------------------------
interface async_queue_source_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    import async_queue_pkg::*;

    localparam int IW = idx_bits(DEPTH);

    logic                     io_enq_valid;
    logic                     io_enq_ready;
    logic [WIDTH-1:0]         io_enq_bits;
    logic [DEPTH*WIDTH-1:0]   io_async_mem;
    logic [IW-1:0]            io_async_widx;
    logic [IW-1:0]            io_async_ridx;
`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
    logic                     io_async_source_valid;
    logic                     io_async_sink_valid;
`endif

    modport master (
        input  io_enq_valid,
        input  io_enq_bits,
        input  io_async_ridx,
`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
        input  io_async_sink_valid,
        output io_async_source_valid,
`endif
        output io_enq_ready,
        output io_async_mem,
        output io_async_widx
    );

    modport slave (
        output io_enq_valid,
        output io_enq_bits,
        output io_async_ridx,
`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
        output io_async_sink_valid,
        input  io_async_source_valid,
`endif
        input  io_enq_ready,
        input  io_async_mem,
        input  io_async_widx
    );

endinterface

// File: rtl/async_reset_sync_shift_reg.sv
// ----------------------------------------------------------------------------
// async_reset_sync_shift_reg
// SYNC-stage shift register of W bits with asynchronous active-low reset to 0.
// Used as a synchroniser for signals arriving from another clock domain and
// as a "ones shift in after reset" delay line.
//   clock : destination clock
//   reset : asynchronous active-low reset
//   d     : input (may be asynchronous to clock)
//   q     : output of the last stage
// ----------------------------------------------------------------------------
module async_reset_sync_shift_reg #(
    parameter int W    = 1,
    parameter int SYNC = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // stg[0] is the capture flop, stg[SYNC-1] feeds q.
    logic [SYNC-1:0][W-1:0] stg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stg <= '0;
        else        stg <= {stg[SYNC-2:0], d};
    end

    assign q = stg[SYNC-1];

endmodule

// File: rtl/async_queue_source.sv
// ----------------------------------------------------------------------------
// async_queue_source
// Enqueue end of the clock-domain-crossing queue, in the producer domain.
// Accepted entries are written into a register ring that the consumer domain
// reads directly; the write position is published as a Gray index and the
// consumer's Gray read index is synchronised back here to detect full.
//   clock, reset : producer clock, asynchronous active-low reset
//   io.io_enq_*  : producer valid/ready stream
//   io.io_async_mem / io_async_widx : ring contents and Gray write index
//   io.io_async_ridx : Gray read index from the consumer (asynchronous)
// Optional feature macro: ASYNC_QUEUE_SOURCE_VALID_EN adds the source/sink
// liveness levels and gates io_enq_ready on both.
// Parameters: WIDTH payload bits, DEPTH ring entries (power of two, >= 2),
// SYNC synchroniser stages (>= 2).
// ----------------------------------------------------------------------------
module async_queue_source
    import async_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int SYNC  = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    async_queue_source_if.master io
);

    localparam int            IW = idx_bits(DEPTH);
    localparam int            AW = IW - 1;
    localparam logic [IW-1:0] G  = IW'(full_mask(DEPTH));

    logic [IW-1:0]                widx_bin;
    logic [IW-1:0]                widx_nxt;
    logic [IW-1:0]                widx_gray;
    logic [IW-1:0]                ridx_sync;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic                         full;
    logic                         ready;
    logic                         fire;

    // Consumer read index into this domain. Gray coding guarantees that the
    // sampled value is either the old or the new index, never a blend.
    async_reset_sync_shift_reg #(.W(IW), .SYNC(SYNC)) u_ridx_sync (
        .clock (clock),
        .reset (reset),
        .d     (io.io_async_ridx),
        .q     (ridx_sync)
    );

    // A stale read index only makes full look true for longer, so a write
    // allowed by this compare can never land on an unread slot.
    assign full = (widx_gray == (ridx_sync ^ G));

`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
    logic source_valid_reg;
    logic sink_valid_sync;

    // Ones shift in after reset release; goes high SYNC cycles later.
    async_reset_sync_shift_reg #(.W(1), .SYNC(SYNC)) u_source_valid (
        .clock (clock),
        .reset (reset),
        .d     (1'b1),
        .q     (source_valid_reg)
    );

    async_reset_sync_shift_reg #(.W(1), .SYNC(SYNC)) u_sink_valid_sync (
        .clock (clock),
        .reset (reset),
        .d     (io.io_async_sink_valid),
        .q     (sink_valid_sync)
    );

    assign io.io_async_source_valid = source_valid_reg;
    assign ready = !full && source_valid_reg && sink_valid_sync;
`else
    assign ready = !full;
`endif

    // ready depends on registers only; valid never feeds back into it.
    assign fire     = io.io_enq_valid && ready;
    assign widx_nxt = widx_bin + IW'(1);

    // Ring slot and index advance on the same edge: the consumer cannot see
    // the new index before it has synchronised it, by which time the slot
    // data has long been stable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            widx_bin  <= '0;
            widx_gray <= '0;
            mem       <= '0;
        end else if (fire) begin
            mem[widx_bin[AW-1:0]] <= io.io_enq_bits;
            widx_bin              <= widx_nxt;
            widx_gray             <= IW'(gray(32'(widx_nxt)));
        end
    end

    // widx leaves straight from its flop: no glitches into the other domain.
    assign io.io_enq_ready  = ready;
    assign io.io_async_widx = widx_gray;
    assign io.io_async_mem  = mem;

endmodule

// File: tb/tb_async_queue_source.sv
// ----------------------------------------------------------------------------
// tb_async_queue_source
// Directed and random stimulus for async_queue_source against a count-based
// model: occupancy = writes - reads seen through the synchroniser delay.
// ----------------------------------------------------------------------------
module tb_async_queue_source;

    localparam int W    = 32;
    localparam int D    = 8;
    localparam int SYNC = 3;
    localparam int IW   = $clog2(D) + 1;

    logic clk;
    logic rst_n;

    async_queue_source_if #(.WIDTH(W), .DEPTH(D)) bus ();

    async_queue_source #(.WIDTH(W), .DEPTH(D), .SYNC(SYNC)) dut (
        .clock (clk),
        .reset (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned wcnt;          // writes, mod 2*D
    int unsigned rcnt;          // consumer reads driven, mod 2*D
    logic [W-1:0] mref [D];
    int unsigned rq[$];         // read count present at each edge since reset
    bit sink;
    bit sq[$];
    int edges;

    function automatic logic [IW-1:0] to_gray(input int unsigned b);
        logic [IW-1:0] x;
        x = IW'(b);
        return x ^ (x >> 1);
    endfunction

    // The synchroniser output after edge n reflects the input at edge n-SYNC+1.
    function automatic bit ready_model();
        int unsigned rs;
        int unsigned occ;
        bit r;
        rs  = (rq.size() >= SYNC) ? rq[rq.size()-SYNC] : 0;
        occ = (wcnt + 2*D - rs) % (2*D);
        r   = (occ != D);
`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
        r = r && (edges >= SYNC) && ((sq.size() >= SYNC) ? sq[sq.size()-SYNC] : 1'b0);
`endif
        return r;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_ready"}, 64'(bus.io_enq_ready), 64'(ready_model()));
        chk({tag, "_widx"}, 64'(bus.io_async_widx), 64'(to_gray(wcnt)));
        for (int i = 0; i < D; i++)
            chk({tag, "_mem"}, 64'(bus.io_async_mem[i*W +: W]), 64'(mref[i]));
`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
        chk({tag, "_srcv"}, 64'(bus.io_async_source_valid), 64'(edges >= SYNC));
`endif
    endtask

    // One producer cycle: drive at posedge+1, model the edge, sample at +1.
    task automatic step(input bit v, input logic [W-1:0] b, output bit fired);
        logic [IW-1:0] prev;
        bit f;
        bus.io_enq_valid  = v;
        bus.io_enq_bits   = b;
        bus.io_async_ridx = to_gray(rcnt);
`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
        bus.io_async_sink_valid = sink;
`endif
        f    = v && ready_model();
        prev = bus.io_async_widx;
        @(posedge clk);
        rq.push_back(rcnt);
        sq.push_back(sink);
        edges++;
        if (f) begin
            mref[wcnt % D] = b;
            wcnt = (wcnt + 1) % (2*D);
        end
        #1;
        check_all("step");
        if (f) chk("widx_1bit", 64'($countones(prev ^ bus.io_async_widx)), 64'd1);
        fired = f;
    endtask

    task automatic model_clear();
        wcnt = 0; rcnt = 0; edges = 0;
        rq.delete(); sq.delete();
        for (int i = 0; i < D; i++) mref[i] = '0;
    endtask

    task automatic do_reset();
        bit f;
        rst_n = 1'b0;
        bus.io_enq_valid = 1'b0;
        model_clear();
        #1;
        check_all("rst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        // the edge above was a real edge after release
        rq.push_back(rcnt); sq.push_back(sink); edges++;
`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
        for (int i = 0; i < SYNC; i++) step(1'b0, '0, f);
`endif
    endtask

    bit fired;
    int n;
    int fcount;
    logic [IW-1:0] exp_seq [8];
    int unsigned whist[$];

    initial begin
        exp_seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
        rst_n = 1'b0;
        sink  = 1'b1;
        bus.io_enq_valid  = 1'b0;
        bus.io_enq_bits   = '0;
        bus.io_async_ridx = '0;
`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
        bus.io_async_sink_valid = 1'b1;
`endif
        model_clear();
        #1;
        chk("reset_widx", 64'(bus.io_async_widx), 64'd0);
        chk("reset_mem0", 64'(bus.io_async_mem[0 +: W]), 64'd0);
`ifndef ASYNC_QUEUE_SOURCE_VALID_EN
        chk("reset_ready", 64'(bus.io_enq_ready), 64'd1);
`endif
        do_reset();

        // fill the ring back to back
        for (int i = 0; i < 8; i++) begin
            step(1'b1, W'(32'hA0 + i), fired);
            chk("fill_fire", 64'(fired), 64'd1);
            chk("fill_gray", 64'(bus.io_async_widx), 64'(exp_seq[i]));
        end
        chk("full_ready", 64'(bus.io_enq_ready), 64'd0);
        step(1'b1, W'(32'hFF), fired);
        chk("ninth_rejected", 64'(fired), 64'd0);
        chk("ninth_mem0", 64'(bus.io_async_mem[0 +: W]), 64'hA0);

        // free one slot; ready follows once the index has crossed the synchroniser
        rcnt = 1;
        n = 0;
        do begin
            step(1'b0, '0, fired);
            n++;
        end while (!bus.io_enq_ready && n < 20);
        // n edges after the cycle in which ridx changed: ridx visible in cycle SYNC
        chk("ready_latency", 64'(n), 64'(SYNC));
        step(1'b1, W'(32'hB0), fired);
        chk("refill_mem0", 64'(bus.io_async_mem[0 +: W]), 64'hB0);
        chk("refill_widx", 64'(bus.io_async_widx), 64'd13);

        // continuous stream with the reader two cycles behind: never full
        do_reset();
        whist.delete();
        fcount = 0;
        for (int i = 0; i < 32; i++) begin
            whist.push_back(wcnt);
            rcnt = (whist.size() > 2) ? whist[whist.size()-3] : 0;
            step(1'b1, W'($urandom), fired);
            if (fired) fcount++;
        end
        chk("stream_fires", 64'(fcount), 64'd32);

        // asynchronous reset in the middle of traffic
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, W'($urandom), fired);
        bus.io_enq_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
        chk("async_rst_ready", 64'(bus.io_enq_ready), 64'd0);
`else
        chk("async_rst_ready", 64'(bus.io_enq_ready), 64'd1);
`endif
        chk("async_rst_widx", 64'(bus.io_async_widx), 64'd0);
        chk("async_rst_mem", 64'(bus.io_async_mem == '0), 64'd1);
        do_reset();

`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
        // consumer liveness gating
        sink = 1'b0;
        for (int i = 0; i < SYNC + 2; i++) step(1'b1, W'($urandom), fired);
        chk("sink_low_ready", 64'(bus.io_enq_ready), 64'd0);
        sink = 1'b1;
        for (int i = 0; i < SYNC; i++) step(1'b0, '0, fired);
        chk("sink_high_ready", 64'(bus.io_enq_ready), 64'd1);
`endif

        // random traffic with a random reader
        for (int i = 0; i < 400; i++) begin
            if (rcnt != wcnt && $urandom_range(1, 0) == 1) rcnt = (rcnt + 1) % (2*D);
`ifdef ASYNC_QUEUE_SOURCE_VALID_EN
            if ($urandom_range(15, 0) == 0) sink = ~sink;
`endif
            step(($urandom_range(3, 0) != 0), W'($urandom), fired);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
